pwm_multi_channel: RTL and testbench

Multi-channel, parametrised successor to the team's single-channel push-button PWM generator. It drives CH independent PWM outputs from one shared period counter. Each channel's duty is stepped up and down by its own pair of debounced push-buttons. Duty updates are shadowed and applied only at the period boundary, so every output period is glitch-free. The block sits directly behind the top-level dedicated inputs and drives the dedicated outputs.

---
 rtl/pwm_multi_channel.sv | 157 +++++++++++++++
 tb/tb_pwm_multi_channel.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: CH PWM outputs driven from one shared period counter.
// Each channel's duty is stepped by its own pair of debounced push-buttons.
// Duty changes are shadowed in duty_next and copied to duty_act only at the
// period boundary, so an output period never changes shape partway through.
// Optional feature macro: PWM_PHASE_STAGGER_EN. When it is defined, channel i
// is shifted by i*(PERIOD/CH) counts to spread its rising edges over the
// period. When it is undefined, all channels are edge-aligned.
module pwm_multi_channel #(
  parameter int CH        = 4,
  parameter int CW        = 8,
  parameter int PERIOD    = 200,
  parameter int STEP      = 20,
  parameter int DUTY_INIT = PERIOD / 2,
  parameter int DEB_DIV   = 250000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [CH-1:0] inc,
  input  logic [CH-1:0] dec,
  output logic [CH-1:0] pwm,
  output logic          wrap
);

  localparam int            PW        = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(DEB_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);
  localparam logic [CW-1:0] PERIOD_C  = CW'(PERIOD);
  localparam logic [CW:0]   PERIOD_W  = (CW+1)'(PERIOD);
  localparam logic [CW-1:0] STEP_C    = CW'(STEP);
  localparam logic [CW:0]   STEP_W    = (CW+1)'(STEP);
  localparam logic [CW-1:0] DUTY_RST  = CW'(DUTY_INIT);

  logic [PW-1:0] pre;
  logic          tick;
  logic [CH-1:0] inc_meta, inc_sync, dec_meta, dec_sync;
  logic [CH-1:0] inc_s1, inc_s2, dec_s1, dec_s2;
  logic [CH-1:0] inc_press, dec_press;
  logic [CW-1:0] cnt;
  logic          wrap_now;

  assign tick     = (pre == PRE_LAST);
  assign wrap_now = ena && (cnt == CNT_LAST);

  // A press is the single tick on which the debounced level first reads high.
  assign inc_press = inc_s1 & ~inc_s2 & {CH{tick}};
  assign dec_press = dec_s1 & ~dec_s2 & {CH{tick}};

  // Debounce sample-rate prescaler, free running, wraps at DEB_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Two-FF synchronisers for the raw buttons, followed by slow debounce samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_meta <= '0;
      inc_sync <= '0;
      dec_meta <= '0;
      dec_sync <= '0;
      inc_s1   <= '0;
      inc_s2   <= '0;
      dec_s1   <= '0;
      dec_s2   <= '0;
    end else begin
      inc_meta <= inc;
      inc_sync <= inc_meta;
      dec_meta <= dec;
      dec_sync <= dec_meta;
      if (tick) begin
        inc_s1 <= inc_sync;
        inc_s2 <= inc_s1;
        dec_s1 <= dec_sync;
        dec_s2 <= dec_s1;
      end
    end
  end

  // Shared period counter plus the registered wrap pulse. The counter is parked at 0 while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_now;
      if (!ena || wrap_now) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic [CW-1:0] duty_next;
    logic [CW-1:0] duty_act;
    logic [CW:0]   up_sum;
    logic [CW-1:0] up_val;
    logic [CW-1:0] dn_val;
    logic [CW:0]   phase;
    logic          pwm_q;

    // The wider sum cannot overflow, so the saturation test is exact.
    assign up_sum = {1'b0, duty_next} + STEP_W;
    assign up_val = (up_sum > PERIOD_W) ? PERIOD_C : up_sum[CW-1:0];
    assign dn_val = (duty_next < STEP_C) ? '0 : (duty_next - STEP_C);

`ifdef PWM_PHASE_STAGGER_EN
    // The offset is always below PERIOD, so a single conditional subtract completes the modulo.
    localparam int          OFFS   = gi * (PERIOD / CH);
    localparam logic [CW:0] OFFS_W = (CW+1)'(OFFS);
    logic [CW:0] phase_sum;
    assign phase_sum = {1'b0, cnt} + OFFS_W;
    assign phase     = (phase_sum >= PERIOD_W) ? (phase_sum - PERIOD_W) : phase_sum;
`else
    assign phase = {1'b0, cnt};
`endif

    // Pending duty: step on a single press, hold when both buttons are pressed in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        duty_next <= DUTY_RST;
      end else if (inc_press[gi] && !dec_press[gi]) begin
        duty_next <= up_val;
      end else if (dec_press[gi] && !inc_press[gi]) begin
        duty_next <= dn_val;
      end
    end

    // Active duty follows the shadow only at a period boundary, or continuously while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        duty_act <= DUTY_RST;
      end else if (!ena || wrap_now) begin
        duty_act <= duty_next;
      end
    end

    // Registered compare output. Duty 0 never matches, and duty PERIOD always matches.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pwm_q <= 1'b0;
      end else begin
        pwm_q <= ena && (phase < {1'b0, duty_act});
      end
    end

    assign pwm[gi] = pwm_q;
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Testbench for pwm_multi_channel with CH=2, CW=4, PERIOD=10, STEP=1, DEB_DIV=2, DUTY_INIT=5.
// Each check captures one 10-cycle output period as bit masks.
module tb_pwm_multi_channel;

  localparam int CH        = 2;
  localparam int CW        = 4;
  localparam int PERIOD    = 10;
  localparam int STEP      = 1;
  localparam int DEB_DIV   = 2;
  localparam int DUTY_INIT = 5;

`ifdef PWM_PHASE_STAGGER_EN
  localparam int OFF1 = 5;
`else
  localparam int OFF1 = 0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena   = 1'b0;
  logic [CH-1:0] inc   = '0;
  logic [CH-1:0] dec   = '0;
  logic [CH-1:0] pwm;
  logic          wrap;

  int n_cmp = 0;
  int n_bad = 0;
  int idle_chk = 0;
  int idle_bad = 0;

  typedef struct {
    int op;   // 0 inc0, 1 dec0, 2 inc1, 3 dec1, 4 inc1+dec1 together
    int n;    // number of separate presses
    int d0;   // expected duty of channel 0 afterwards
    int d1;   // expected duty of channel 1 afterwards
  } vec_t;

  vec_t vecs [8];

  pwm_multi_channel #(
    .CH(CH), .CW(CW), .PERIOD(PERIOD), .STEP(STEP),
    .DUTY_INIT(DUTY_INIT), .DEB_DIV(DEB_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .inc(inc), .dec(dec), .pwm(pwm), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (idle_chk != 0 && (pwm != '0 || wrap != 1'b0)) idle_bad++;
  endtask

  task automatic press(input int op);
    @(negedge clk);
    case (op)
      0: inc[0] = 1'b1;
      1: dec[0] = 1'b1;
      2: inc[1] = 1'b1;
      3: dec[1] = 1'b1;
      default: begin inc[1] = 1'b1; dec[1] = 1'b1; end
    endcase
    repeat (8) step();
    inc = '0;
    dec = '0;
    repeat (8) step();
  endtask

  task automatic wait_wrap(input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (wrap) begin
        seen = 1;
        break;
      end
    end
    check({name, "_wrap_seen"}, seen, 1);
  endtask

  // Capture the next 10 samples and compare them with hand-derived waveforms.
  task automatic check_period(input string name, input int d0, input int d1);
    int m0, m1, mw, e0, e1, ew;
    m0 = 0; m1 = 0; mw = 0; e0 = 0; e1 = 0; ew = 0;
    for (int j = 0; j < PERIOD; j++) begin
      @(negedge clk);
      if (pwm[0]) m0 |= (1 << j);
      if (pwm[1]) m1 |= (1 << j);
      if (wrap)   mw |= (1 << j);
      if (j < d0) e0 |= (1 << j);
      if (((j + OFF1) % PERIOD) < d1) e1 |= (1 << j);
      if (j == PERIOD - 1) ew |= (1 << j);
    end
    $display("period %s: pwm0=%b pwm1=%b wrap=%b", name, m0[9:0], m1[9:0], mw[9:0]);
    check({name, "_pwm0"}, m0, e0);
    check({name, "_pwm1"}, m1, e1);
    check({name, "_wrap"}, mw, ew);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{op: 0, n: 7,  d0: 10, d1: 5};   // saturate high
    vecs[1] = '{op: 1, n: 12, d0: 0,  d1: 5};   // saturate low
    vecs[2] = '{op: 1, n: 1,  d0: 0,  d1: 5};   // no wrap below zero
    vecs[3] = '{op: 0, n: 3,  d0: 3,  d1: 5};
    vecs[4] = '{op: 4, n: 1,  d0: 3,  d1: 5};   // simultaneous inc/dec
    vecs[5] = '{op: 3, n: 2,  d0: 3,  d1: 3};
    vecs[6] = '{op: 2, n: 9,  d0: 3,  d1: 10};
    vecs[7] = '{op: 3, n: 4,  d0: 3,  d1: 6};

    // Reset held for three cycles with ena already high.
    rst_n = 1'b0;
    ena   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_pwm", int'(pwm), 0);
    check("reset_wrap", int'(wrap), 0);
    rst_n = 1'b1;
    check_period("after_reset", 5, 5);

    // Hold inc[0] for 20 cycles, starting just after a wrap.
    inc[0] = 1'b1;
    check_period("press_period", 5, 5);
    check_period("after_press", 6, 5);
    inc[0] = 1'b0;
    repeat (8) step();
    wait_wrap("held_once");
    check_period("held_once", 6, 5);

    for (int v = 0; v < 8; v++) begin
      $display("vec %0d: op=%0d presses=%0d expect duty %0d/%0d", v, vecs[v].op, vecs[v].n, vecs[v].d0, vecs[v].d1);
      for (int k = 0; k < vecs[v].n; k++) press(vecs[v].op);
      wait_wrap($sformatf("vec%0d", v));
      check_period($sformatf("vec%0d", v), vecs[v].d0, vecs[v].d1);
    end

    // Disable the block while stepping channel 0 from 3 to 4.
    @(negedge clk);
    ena = 1'b0;
    step();
    idle_chk = 1;
    press(0);
    idle_chk = 0;
    check("ena_low_idle", idle_bad, 0);
    ena = 1'b1;
    check_period("resume", 4, 6);

    // Apply an asynchronous reset partway through a period.
    step();
    step();
    check("pre_reset_pwm0", int'(pwm[0]), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_pwm", int'(pwm), 0);
    check("async_reset_wrap", int'(wrap), 0);
    step();
    step();
    rst_n = 1'b1;
    check_period("post_reset", 5, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
